// File: rtl/rx_buf_pkg.sv
// Shared defaults and helpers for the receive capture buffer.
package rx_buf_pkg;

  localparam int RX_DATA_W_DEF = 8;
  localparam int RX_DEPTH_DEF  = 16;
  localparam int RX_CNT_W_DEF  = 16;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/rx_buf_ram.sv
// Storage array for the receive buffer: synchronous write, asynchronous read.
module rx_buf_ram
  import rx_buf_pkg::*;
#(
  parameter int DATA_W = RX_DATA_W_DEF,
  parameter int DEPTH  = RX_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [ptr_w(DEPTH)-1:0]  waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [ptr_w(DEPTH)-1:0]  raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rx_buffer_ctrl.sv
// Receive-side FIFO controller: captures receiver words, throttles the
// receiver near full, and reports drops plus an accepted-word count.
module rx_buffer_ctrl
  import rx_buf_pkg::*;
#(
  parameter int DATA_W    = RX_DATA_W_DEF,
  parameter int DEPTH     = RX_DEPTH_DEF,
  parameter int AFULL_LVL = DEPTH - 2,
  parameter int CNT_W     = RX_CNT_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rx_done_sig,
  input  logic [DATA_W-1:0]          rx_data,
  output logic                       rx_en_sig,
  output logic [DATA_W-1:0]          number_data,
  output logic                       data_valid,
  input  logic                       data_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  input  logic                       clr_ovf,
  output logic [CNT_W-1:0]           rx_count
);

  localparam int PW = ptr_w(DEPTH);
  localparam int LW = PW + 1;

  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]    level_reg, level_next;
  logic             rx_en_reg, ovf_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             full, pop, push, drop;

  always_comb begin
    full       = (level_reg == LW'(DEPTH));
    pop        = (level_reg != '0) && data_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    push       = rx_done_sig && (!full || pop);
    drop       = rx_done_sig && full && !pop;
    level_next = level_reg + LW'(push) - LW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      rx_en_reg  <= 1'b0;
      ovf_reg    <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      level_reg <= level_next;
      rx_en_reg <= (level_next < LW'(AFULL_LVL));
      // Set has priority over clear so a drop is never lost.
      if (drop)         ovf_reg <= 1'b1;
      else if (clr_ovf) ovf_reg <= 1'b0;
      if (push) cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  rx_buf_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push && !rst),
    .waddr (wr_ptr_reg),
    .wdata (rx_data),
    .raddr (rd_ptr_reg),
    .rdata (number_data)
  );

  assign data_valid = (level_reg != '0);
  assign level      = level_reg;
  assign rx_en_sig  = rx_en_reg;
  assign overflow   = ovf_reg;
  assign rx_count   = cnt_reg;

endmodule

// File: doc/rx_buffer_ctrl.md
# rx_buffer_ctrl

Parametrised receive-side capture buffer between the UART receiver and its consumer logic. It captures each word the receiver flags with `rx_done_sig` into a DEPTH-entry FIFO and presents words through a valid/ready interface. It throttles the receiver through `rx_en_sig` when the FIFO nears full, and reports drops and an accepted-word count.

## Interface
- `DATA_W`, default 8: received word width.
- `DEPTH`, default 16: FIFO entries. Must be a power of two and at least 2.
- `AFULL_LVL`, default `DEPTH-2`: occupancy at or above which `rx_en_sig` is deasserted. Legal range is 1..DEPTH.
- `CNT_W`, default 16: width of the accepted-word counter.
- `clk`, in, 1: sole clock. All logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `rx_done_sig`, in, 1: one-cycle pulse from the receiver; `rx_data` is valid in that cycle.
- `rx_data`, in, `DATA_W`: received word.
- `rx_en_sig`, out, 1: receive enable back to the receiver.
- `number_data`, out, `DATA_W`: head-of-FIFO word.
- `data_valid`, out, 1: `number_data` is valid.
- `data_ready`, in, 1: consumer accepts the head word.
- `level`, out, `$clog2(DEPTH)+1`: current occupancy, 0..DEPTH.
- `overflow`, out, 1: sticky flag; a word arrived while the FIFO was full.
- `clr_ovf`, in, 1: clears `overflow`.
- `rx_count`, out, `CNT_W`: count of accepted words.

## Operation
Reset is synchronous and active-high; it applies on the rising edge of `clk` while `rst`=1. Reset values:
- `level`=0, `data_valid`=0.
- `rx_en_sig`=0, `overflow`=0, `rx_count`=0.
- Read and write pointers = 0.
- `number_data` is don't-care while `data_valid`=0.

Per cycle, a pop and a push are evaluated against the pre-edge state:
- **pop** = `data_valid` && `data_ready`. It advances the read pointer.
- **push** = `rx_done_sig` && (`level` < DEPTH || pop).
  - When full, a simultaneous pop frees the slot, so the push is accepted.
  - A push writes `rx_data` at the write pointer and advances it.
- **drop** = `rx_done_sig` && `level`==DEPTH && !pop.
  - The word is discarded and the FIFO contents are unchanged.
  - `overflow` is set.
- **Level update:**
  - `level` += push − pop.
  - Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH.
- **Flow control:**
  - `rx_en_sig` is a register.
  - Its next value is (`level_next` < `AFULL_LVL`), where `level_next` is the post-update occupancy.
  - The receiver may still deliver words after deassertion; they are buffered while space remains and dropped once full.
- **Overflow flag:**
  - `overflow` is set by drop and cleared by `clr_ovf`.
  - If both occur in the same cycle, set wins (`overflow`=1).
- **Counter:**
  - `rx_count` += 1 on each push.
  - It wraps from 2^`CNT_W`−1 to 0.
  - Drops are not counted.
- **Read interface:**
  - `data_valid` = (`level` != 0).
  - `number_data` = storage at the read pointer.
  - Both are driven from registered state, with no combinational path from `rx_done_sig`.
  - `number_data` must hold stable while `data_valid`=1 and no pop occurs.
- **Reset mid-operation:**
  - All contents are discarded.
  - A `rx_done_sig` in a reset cycle is ignored.
  - `data_ready` in a reset cycle is ignored.

## Timing
- **Push to visibility:** a push at edge N into an empty FIFO gives `data_valid`=1 and `number_data`=word in cycle N+1.
- **Pop:**
  - A pop at edge N shows the next word, or `data_valid`=0, in cycle N+1.
  - Sustained throughput is one word per cycle.
- **Flow control:** `rx_en_sig` reflects occupancy with one cycle of latency.
- **Release from reset:** `rx_en_sig` rises at the first edge after `rst` deasserts.
- **Counters and flags:** `level`, `overflow` and `rx_count` update at the same edge as the causing push, pop or drop.

## Structure
- Package `rx_buf_pkg` holds:
  - `RX_DATA_W_DEF`=8, `RX_DEPTH_DEF`=16, `RX_CNT_W_DEF`=16.
  - `function automatic int ptr_w(int depth)` returning `$clog2(depth)`.
- Sub-module `rx_buf_ram`:
  - DEPTH×DATA_W register array.
  - One synchronous write port and one asynchronous read port.
  - No reset on its contents.
- `rx_buffer_ctrl` contains:
  - the pointers and level;
  - the push/pop/drop decode;
  - the `rx_en_sig`, `overflow` and `rx_count` registers.

## Test plan
All scenarios use DATA_W=8, DEPTH=4, AFULL_LVL=2, CNT_W=4.
- **Basic transfer:**
  - Stimulus: reset, then push 0x41 with `data_ready`=0.
  - Response: next cycle `data_valid`=1, `number_data`=0x41, `level`=1.
  - Then `data_ready`=1 for one cycle: the following cycle `data_valid`=0 and `level`=0.
- **Fill, flow control and drop:**
  - Stimulus: push 0x01..0x04 back-to-back with `data_ready`=0.
  - Response: `rx_en_sig` falls the cycle after `level` reaches 2, and `level`=4.
  - Stimulus: push 0x05.
  - Response: `overflow`=1, `level`=4, `rx_count`=4.
  - Stimulus: drain all entries.
  - Response: `number_data` reads 0x01, 0x02, 0x03, 0x04 in order; `rx_en_sig` rises once `level` < 2.
- **Simultaneous push and pop when full:**
  - Stimulus: with `level`=4, hold `data_ready`=1 and push 0xAA in the same cycle.
  - Response: no drop, `level`=4, `overflow` unchanged, and 0xAA emerges after three further words.
- **Overflow set versus clear:**
  - Stimulus: pulse `clr_ovf` in the same cycle as a drop.
  - Response: `overflow`=1.
  - Stimulus: pulse `clr_ovf` alone.
  - Response: `overflow`=0 the next cycle.
- **Counter and pointer wrap:**
  - Stimulus: stream 17 words with `data_ready`=1 throughout.
  - Response: `rx_count`=1 (wrapped past 15), every word is received in order, and pointers wrap cleanly with `level` ≤ 1.
- **Reset mid-operation:**
  - Stimulus: with `level`=3 and `overflow`=1, assert `rst` for one cycle together with `rx_done_sig`.
  - Response: next cycle `level`=0, `data_valid`=0, `overflow`=0, `rx_count`=0, `rx_en_sig`=0; `rx_en_sig`=1 one cycle after that.
